mtm_alu_ctrl: RTL and testbench

Sequencer between the serial-input deserializer, the 32-bit ALU and the serial-output serializer.
- Takes one decoded request per packet (A, B, CTL) and validates the opcode.
- Issues a one-cycle start to the ALU and waits for done.
- Assembles the result or error response and hands it to the serializer over a valid/ready handshake.
- Single request in flight; no queueing.

---
 rtl/mtm_alu_pkg.sv | 15 +
 rtl/mtm_alu_ctrl_if.sv | 24 ++
 rtl/mtm_alu_crc3.sv | 12 +
 rtl/mtm_alu_ctrl.sv | 112 +++++++++++
 tb/tb_mtm_alu_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: opcodes, response codes and sequencer state shared by the mtm_alu blocks.
package mtm_alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;
  localparam logic [7:0] ERR_OP   = 8'h93;
  localparam logic [7:0] CTL_IDLE = 8'hFF;
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WAIT, SEND} ctrl_state_e;
  function automatic logic op_valid(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
  endfunction
endpackage

// File: rtl/mtm_alu_ctrl_if.sv
// mtm_alu_ctrl_if: deserializer request, ALU and serializer response signals of the sequencer.
interface mtm_alu_ctrl_if;
  logic        des_valid;
  logic [31:0] des_A, des_B;
  logic [7:0]  des_CTL;
  logic        alu_start;
  logic [31:0] alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [31:0] alu_C;
  logic [3:0]  alu_flags;
  logic        ser_valid, ser_ready;
  logic [31:0] ser_C;
  logic [7:0]  ser_CTL;
  logic        busy, ovr;
  modport master (
    output des_valid, des_A, des_B, des_CTL, alu_done, alu_C, alu_flags, ser_ready,
    input  alu_start, alu_A, alu_B, alu_op, ser_valid, ser_C, ser_CTL, busy, ovr
  );
  modport slave (
    input  des_valid, des_A, des_B, des_CTL, alu_done, alu_C, alu_flags, ser_ready,
    output alu_start, alu_A, alu_B, alu_op, ser_valid, ser_C, ser_CTL, busy, ovr
  );
endinterface

// File: rtl/mtm_alu_crc3.sv
// mtm_alu_crc3: combinational CRC3 (x^3+x+1, init 0) over 37 bits, MSB first.
module mtm_alu_crc3 (
  input  logic [36:0] data_i,
  output logic [2:0]  crc_o
);
  logic [2:0] c;
  always_comb begin
    c = '0;
    for (int i = 36; i >= 0; i--) c = {c[1], c[0] ^ c[2] ^ data_i[i], c[2] ^ data_i[i]};
    crc_o = c;
  end
endmodule

// File: rtl/mtm_alu_ctrl.sv
// mtm_alu_ctrl: single-request sequencer between deserializer, ALU and serializer.
// Define MTM_ALU_CTRL_TIMEOUT_EN to abort WAIT with ERR_DATA after TIMEOUT_CYC cycles.
module mtm_alu_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W = 7
) (
  input logic           clk,
  input logic           rst_n,
  mtm_alu_ctrl_if.slave bus
);
  ctrl_state_e state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d, c_q, c_d;
  logic [7:0]  ctl_q, ctl_d, sctl_q, sctl_d;
  logic [2:0]  op_q, op_d, crc;
  logic        ovr_q, timeout;
  if (2 ** TO_W <= TIMEOUT_CYC) begin : g_to_w_chk
    $error("TO_W too narrow for TIMEOUT_CYC");
  end
  mtm_alu_crc3 u_crc (.data_i({bus.alu_C, 1'b0, bus.alu_flags}), .crc_o(crc));
`ifdef MTM_ALU_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] to_q;
  assign timeout = to_q == TO_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_q <= '0;
    else to_q <= state_q == WAIT ? to_q + TO_W'(1) : '0;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    ctl_d = ctl_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    op_d = op_q;
    c_d = c_q;
    sctl_d = sctl_q;
    unique case (state_q)
      IDLE: if (bus.des_valid) begin
        a_d = bus.des_A;
        b_d = bus.des_B;
        ctl_d = bus.des_CTL;
        state_d = DECODE;
      end
      DECODE: if (ctl_q == ERR_DATA || ctl_q == ERR_CRC) begin
        c_d = '0;
        sctl_d = ctl_q;
        state_d = SEND;
      end else if (ctl_q[7]) begin
        state_d = IDLE;
      end else if (!op_valid(ctl_q[6:4])) begin
        c_d = '0;
        sctl_d = ERR_OP;
        state_d = SEND;
      end else begin
        alu_a_d = a_q;
        alu_b_d = b_q;
        op_d = ctl_q[6:4];
        state_d = EXEC;
      end
      EXEC: state_d = WAIT;
      // a done coinciding with expiry still delivers the result
      WAIT: if (bus.alu_done) begin
        c_d = bus.alu_C;
        sctl_d = {1'b0, bus.alu_flags, crc};
        state_d = SEND;
      end else if (timeout) begin
        c_d = '0;
        sctl_d = ERR_DATA;
        state_d = SEND;
      end
      SEND: state_d = bus.ser_ready ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ctl_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      op_q <= '0;
      c_q <= '0;
      sctl_q <= CTL_IDLE;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      ctl_q <= ctl_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      op_q <= op_d;
      c_q <= c_d;
      sctl_q <= sctl_d;
      ovr_q <= bus.des_valid && state_q != IDLE;
    end
  assign bus.alu_start = state_q == EXEC;
  assign bus.alu_A = alu_a_q;
  assign bus.alu_B = alu_b_q;
  assign bus.alu_op = op_q;
  assign bus.ser_valid = state_q == SEND;
  assign bus.ser_C = c_q;
  assign bus.ser_CTL = sctl_q;
  assign bus.busy = state_q != IDLE;
  assign bus.ovr = ovr_q;
endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// tb_mtm_alu_ctrl: scoreboard bench for mtm_alu_ctrl with a behavioural ALU.
// Timeout checks follow MTM_ALU_CTRL_TIMEOUT_EN.
module tb_mtm_alu_ctrl;
  import mtm_alu_pkg::*;
  typedef struct packed {logic [31:0] c; logic [7:0] ctl;} resp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mtm_alu_ctrl_if bus ();
  mtm_alu_ctrl #(.TIMEOUT_CYC(64), .TO_W(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  resp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int alu_lat = 1;
  logic alu_en = 1'b1;

  function automatic logic [2:0] crc3_model(input logic [36:0] d);
    logic [39:0] r = {d, 3'b000};
    for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [35:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s = '0;
    logic [31:0] c = '0;
    logic cy = 1'b0, ov = 1'b0;
    case (op)
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; c = s[31:0]; cy = s[32]; ov = a[31] == b[31] && c[31] != a[31]; end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; c = s[31:0]; cy = s[32]; ov = a[31] != b[31] && c[31] != a[31]; end
      default: c = '0;
    endcase
    return {cy, ov, c == 32'h0, c[31], c};
  endfunction

  function automatic resp_t exp_ok(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [35:0] m = alu_model(op, a, b);
    return {m[31:0], 1'b0, m[35:32], crc3_model({m[31:0], 1'b0, m[35:32]})};
  endfunction

  initial begin : alu_mock
    logic [35:0] m;
    bus.alu_done = 1'b0;
    bus.alu_C = '0;
    bus.alu_flags = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.alu_start && alu_en) begin
        m = alu_model(bus.alu_op, bus.alu_A, bus.alu_B);
        repeat (alu_lat) @(posedge clk);
        #1;
        {bus.alu_flags, bus.alu_C} = m;
        bus.alu_done = 1'b1;
        @(posedge clk);
        #1;
        bus.alu_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl);
    bus.des_valid = 1'b1;
    bus.des_A = a;
    bus.des_B = b;
    bus.des_CTL = ctl;
    tick();
    bus.des_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!bus.ser_valid && cyc < max) begin
      tick();
      cyc++;
    end
    if (!bus.ser_valid) cyc = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    n_cmp++;
    if ({bus.alu_start, bus.alu_A, bus.alu_B, bus.alu_op} !== 68'h0) begin
      n_err++;
      $display("FAIL reset_alu: got %h want 0", {bus.alu_start, bus.alu_A, bus.alu_B, bus.alu_op});
    end
    n_cmp++;
    if ({bus.ser_valid, bus.ser_C, bus.ser_CTL} !== {1'b0, 32'h0, 8'hFF}) begin
      n_err++;
      $display("FAIL reset_ser: got %b/%h/%h want 0/0/ff", bus.ser_valid, bus.ser_C, bus.ser_CTL);
    end
    n_cmp++;
    if ({bus.busy, bus.ovr} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_status: got busy/ovr %b want 00", {bus.busy, bus.ovr});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add;
    resp_t e;
    alu_lat = 1;
    sb.push_back(exp_ok(OP_ADD, 32'd1, 32'd2));
    drive_pkt(32'd1, 32'd2, {1'b0, OP_ADD, 4'h6});
    n_cmp++;
    if ({bus.busy, bus.alu_start} !== 2'b10) begin
      n_err++;
      $display("FAIL add_c1: got busy/start %b want 10", {bus.busy, bus.alu_start});
    end
    tick();
    n_cmp++;
    if ({bus.alu_start, bus.alu_op, bus.alu_A, bus.alu_B} !== {1'b1, OP_ADD, 32'd1, 32'd2}) begin
      n_err++;
      $display("FAIL add_start: got %b/%b/%h/%h want 1/100/1/2", bus.alu_start, bus.alu_op, bus.alu_A, bus.alu_B);
    end
    tick();
    n_cmp++;
    if ({bus.alu_start, bus.ser_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL add_c3: got start/valid %b want 00", {bus.alu_start, bus.ser_valid});
    end
    tick();
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ser_valid, bus.ser_C, bus.ser_CTL} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL add_resp: got %b/%h/%h want 1/%h/%h", bus.ser_valid, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
    end
    n_cmp++;
    if ({bus.ser_C, bus.ser_CTL[7:3]} !== {32'd3, 5'b00000}) begin
      n_err++;
      $display("FAIL add_value: got %h/%b want 3/00000", bus.ser_C, bus.ser_CTL[7:3]);
    end
    tick();
    n_cmp++;
    if ({bus.ser_valid, bus.busy, bus.ser_C} !== {2'b00, 32'd3}) begin
      n_err++;
      $display("FAIL add_after: got %b/%b/%h want 0/0/3", bus.ser_valid, bus.busy, bus.ser_C);
    end
  endtask

  task automatic test_ops;
    logic [2:0] ops [7] = '{OP_AND, OP_OR, OP_SUB, OP_ADD, OP_ADD, OP_SUB, OP_AND};
    logic [31:0] as [7] = '{32'hF0F0_1234, 32'h0F0F_0000, 32'h5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF0F0_F0F0};
    logic [31:0] bs [7] = '{32'hFF00_FF00, 32'h0000_00F0, 32'h9, 32'h1, 32'h1, 32'h1, 32'h0F0F_0F0F};
    resp_t e;
    int cyc;
    for (int i = 0; i < 7; i++) begin
      alu_lat = 1 + i % 4;
      sb.push_back(exp_ok(ops[i], as[i], bs[i]));
      drive_pkt(as[i], bs[i], {1'b0, ops[i], 4'(i)});
      wait_valid(40, cyc);
      e = sb.pop_front();
      n_cmp++;
      if (cyc < 0) begin
        n_err++;
        $display("FAIL op%0d_timeout: no ser_valid within 40 cycles", i);
      end else if ({bus.ser_C, bus.ser_CTL} !== e) begin
        n_err++;
        $display("FAIL op%0d_resp: got %h/%h want %h/%h", i, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
      end
      tick();
    end
    alu_lat = 1;
  endtask

  task automatic test_bad_op;
    logic [2:0] bad [4] = '{3'b010, 3'b011, 3'b110, 3'b111};
    resp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({32'h0, ERR_OP});
      drive_pkt($urandom, $urandom, {1'b0, bad[i], 4'hA});
      tick();
      n_cmp++;
      if ({bus.alu_start, bus.ser_valid} !== 2'b01) begin
        n_err++;
        $display("FAIL badop%0d_timing: got start/valid %b want 01", i, {bus.alu_start, bus.ser_valid});
      end
      e = sb.pop_front();
      n_cmp++;
      if ({bus.ser_C, bus.ser_CTL} !== e) begin
        n_err++;
        $display("FAIL badop%0d_resp: got %h/%h want %h/%h", i, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
      end
      tick();
    end
  endtask

  task automatic test_des_err;
    logic [7:0] codes [2] = '{ERR_CRC, ERR_DATA};
    logic [7:0] drops [2] = '{8'hFF, 8'h80};
    resp_t e;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      sb.push_back({32'h0, codes[i]});
      drive_pkt(32'hDEAD_BEEF, 32'h1234_5678, codes[i]);
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({bus.ser_valid, bus.ser_C, bus.ser_CTL} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL deserr%0d_resp: got %b/%h/%h want 1/%h/%h", i, bus.ser_valid, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive_pkt(32'h1, 32'h1, drops[i]);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL drop%0d_busy1: got %b want 1", i, bus.busy);
      end
      tick();
      n_cmp++;
      if ({bus.busy, bus.ser_valid, bus.ser_CTL} !== {2'b00, ERR_DATA}) begin
        n_err++;
        $display("FAIL drop%0d_idle: got %b/%b/%h want 0/0/c9", i, bus.busy, bus.ser_valid, bus.ser_CTL);
      end
      wait_valid(8, cyc);
      n_cmp++;
      if (cyc != -1) begin
        n_err++;
        $display("FAIL drop%0d_noresp: got ser_valid after %0d cycles want none", i, cyc);
      end
    end
  endtask

  task automatic test_back_to_back;
    resp_t e;
    int cyc;
    int ovr_n = 0;
    bus.ser_ready = 1'b0;
    alu_lat = 1;
    sb.push_back(exp_ok(OP_SUB, 32'h0000_0100, 32'h0000_0001));
    drive_pkt(32'h0000_0100, 32'h0000_0001, {1'b0, OP_SUB, 4'h3});
    wait_valid(20, cyc);
    n_cmp++;
    if (cyc != 3) begin
      n_err++;
      $display("FAIL bp_latency: got %0d want 3", cyc);
    end
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({bus.ser_valid, bus.ser_C, bus.ser_CTL} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got %b/%h/%h want 1/%h/%h", i, bus.ser_valid, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
      end
      if (bus.ovr) ovr_n++;
      bus.des_valid = i == 3;
      bus.des_A = 32'h5555_5555;
      bus.des_B = 32'h2222_2222;
      bus.des_CTL = {1'b0, OP_ADD, 4'h1};
      tick();
    end
    n_cmp++;
    if (ovr_n != 1) begin
      n_err++;
      $display("FAIL bp_ovr: got %0d pulses want 1", ovr_n);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ser_valid, bus.ser_C, bus.ser_CTL} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL bp_accept: got %b/%h/%h want 1/%h/%h", bus.ser_valid, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
    end
    bus.ser_ready = 1'b1;
    bus.des_valid = 1'b1;
    bus.des_CTL = {1'b0, OP_OR, 4'h2};
    tick();
    bus.des_valid = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.ovr, bus.ser_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL bp_accept_drop: got busy/ovr/valid %b want 010", {bus.busy, bus.ovr, bus.ser_valid});
    end
    wait_valid(10, cyc);
    n_cmp++;
    if (cyc != -1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_dropped: got valid_cyc %0d busy %b want -1/0", cyc, bus.busy);
    end
  endtask

  task automatic test_timeout;
    int cyc;
`ifdef MTM_ALU_CTRL_TIMEOUT_EN
    resp_t e;
    alu_en = 1'b0;
    sb.push_back({32'h0, ERR_DATA});
    drive_pkt(32'd1, 32'd2, {1'b0, OP_ADD, 4'h0});
    tick(2);
    wait_valid(200, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 64 || {bus.ser_C, bus.ser_CTL} !== e) begin
      n_err++;
      $display("FAIL timeout: got cyc %0d %h/%h want 64 %h/%h", cyc, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
    end
    tick();
    alu_en = 1'b1;
    alu_lat = 64;
    sb.push_back(exp_ok(OP_SUB, 32'd10, 32'd3));
    drive_pkt(32'd10, 32'd3, {1'b0, OP_SUB, 4'h0});
    tick(2);
    wait_valid(200, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 64 || {bus.ser_C, bus.ser_CTL} !== e) begin
      n_err++;
      $display("FAIL timeout_done_wins: got cyc %0d %h/%h want 64 %h/%h", cyc, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
    end
    tick();
`else
    alu_en = 1'b0;
    drive_pkt(32'd1, 32'd2, {1'b0, OP_ADD, 4'h0});
    tick(2);
    wait_valid(1000, cyc);
    n_cmp++;
    if (cyc != -1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL no_timeout: got valid_cyc %0d busy %b want -1/1", cyc, bus.busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif
    alu_en = 1'b1;
    alu_lat = 1;
  endtask

  task automatic test_reset_wait;
    resp_t e;
    int cyc;
    alu_lat = 20;
    drive_pkt(32'h0000_00AA, 32'h0000_0055, {1'b0, OP_ADD, 4'h0});
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.alu_start, bus.alu_A, bus.alu_B, bus.alu_op} !== 69'h0) begin
      n_err++;
      $display("FAIL rstwait_alu: got %b/%h/%h/%b want all 0", bus.busy, bus.alu_A, bus.alu_B, bus.alu_op);
    end
    n_cmp++;
    if ({bus.ser_valid, bus.ser_C, bus.ser_CTL} !== {1'b0, 32'h0, 8'hFF}) begin
      n_err++;
      $display("FAIL rstwait_ser: got %b/%h/%h want 0/0/ff", bus.ser_valid, bus.ser_C, bus.ser_CTL);
    end
    tick();
    rst_n = 1'b1;
    wait_valid(40, cyc);
    n_cmp++;
    if (cyc != -1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstwait_late_done: got valid_cyc %0d busy %b want -1/0", cyc, bus.busy);
    end
    alu_lat = 2;
    sb.push_back(exp_ok(OP_ADD, 32'h1234, 32'h4321));
    drive_pkt(32'h1234, 32'h4321, {1'b0, OP_ADD, 4'h0});
    wait_valid(20, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 4 || {bus.ser_C, bus.ser_CTL} !== e) begin
      n_err++;
      $display("FAIL rstwait_next: got cyc %0d %h/%h want 4 %h/%h", cyc, bus.ser_C, bus.ser_CTL, e.c, e.ctl);
    end
    tick();
    alu_lat = 1;
  endtask

  initial begin
    bus.des_valid = 1'b0;
    bus.des_A = '0;
    bus.des_B = '0;
    bus.des_CTL = '0;
    bus.ser_ready = 1'b1;
    test_reset();
    test_add();
    test_ops();
    test_bad_op();
    test_des_err();
    test_back_to_back();
    test_timeout();
    test_reset_wait();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
